// File: rtl/seq_normalizer.sv
// Multi-cycle left normalizer: shifts a word left one bit per cycle until its MSB is set,
// reporting the shift count (leading zeros) and an all-zero flag over valid/ready handshakes.
module seq_normalizer #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shift,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [WIDTH-1:0] work_shifted;
    logic [SW-1:0]    count_reg, count_next;
    logic             zero_reg, zero_next;

    // One-bit left shift with zero fill.
    assign work_shifted[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign work_shifted[gi] = work_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            count_reg <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
            zero_reg  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        zero_next  = zero_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_data;
                    count_next = '0;
                    zero_next  = 1'b0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (work_reg == '0) begin
                    zero_next  = 1'b1;
                    state_next = HOLD;
                end else if (work_reg[WIDTH-1]) begin
                    state_next = HOLD;
                end else begin
                    // MSB is reached within WIDTH-1 shifts, so the counter cannot wrap.
                    work_next  = work_shifted;
                    count_next = count_reg + SW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs come straight from registered state so nothing is combinational from inputs.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == HOLD);
    assign out_data  = work_reg;
    assign out_shift = count_reg;
    assign out_zero  = zero_reg;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed testbench for seq_normalizer (WIDTH=4) using immediate assertions at each check.
module tb_seq_normalizer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_shift;
    logic       out_zero;

    int n_asserts;
    int n_fails;

    seq_normalizer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid after acceptance; returns cycles elapsed.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    // One transaction with out_ready=1: offer, accept, wait, check result and release.
    task automatic run_item(input string tag, input logic [3:0] d, input logic [3:0] ed,
                            input logic [1:0] es, input logic ez, input int elat);
        int cyc;
        in_data  = d;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_result(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        check({tag, "_data"}, 32'(out_data), 32'(ed));
        check({tag, "_shift"}, 32'(out_shift), 32'(es));
        check({tag, "_zero"}, 32'(out_zero), 32'(ez));
        $display("item %s: in=%b out_data=%b out_shift=%0d out_zero=%0d latency=%0d",
                 tag, d, out_data, out_shift, out_zero, cyc);
        tick();
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [3:0] exp_d [16];
    logic [1:0] exp_s [16];

    initial begin
        int cyc;
        n_asserts = 0;
        n_fails   = 0;
        exp_d = '{4'b0000, 4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b1010, 4'b1100, 4'b1110,
                  4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        exp_s = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1,
                  2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_shift", 32'(out_shift), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Tests 1-3
        run_item("t1_1010", 4'b1010, 4'b1010, 2'd0, 1'b0, 1);
        run_item("t2_0001", 4'b0001, 4'b1000, 2'd3, 1'b0, 4);
        run_item("t3_0000", 4'b0000, 4'b0000, 2'd0, 1'b1, 1);

        // Test 4: consumer stall with a competing input offered throughout
        out_ready = 1'b0;
        in_data   = 4'b0110;
        in_valid  = 1'b1;
        tick();
        in_data = 4'b1111;
        wait_result(cyc);
        check("t4_latency", 32'(cyc), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data", 32'(out_data), 32'b1100);
            check("t4_hold_shift", 32'(out_shift), 32'd1);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        $display("item t4_0110 stalled: out_data=%b out_shift=%0d", out_data, out_shift);
        out_ready = 1'b1;
        tick();
        check("t4_release_valid", 32'(out_valid), 32'd0);
        check("t4_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_result(cyc);
        check("t4_next_latency", 32'(cyc), 32'd1);
        check("t4_next_data", 32'(out_data), 32'b1111);
        check("t4_next_shift", 32'(out_shift), 32'd0);
        $display("item t4_1111: out_data=%b out_shift=%0d", out_data, out_shift);
        tick();

        // Test 5: reset during SHIFT of 0001
        in_data  = 4'b0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        check("t5_rst_shift", 32'(out_shift), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        run_item("t5_1111", 4'b1111, 4'b1111, 2'd0, 1'b0, 1);

        // Test 6: all inputs back-to-back with in_valid held high
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 4'(i);
            check("t6_in_ready", 32'(in_ready), 32'd1);
            tick();
            wait_result(cyc);
            check("t6_latency", 32'(cyc), 32'(exp_s[i]) + 32'd1);
            check("t6_data", 32'(out_data), 32'(exp_d[i]));
            check("t6_shift", 32'(out_shift), 32'(exp_s[i]));
            check("t6_zero", 32'(out_zero), (i == 0) ? 32'd1 : 32'd0);
            if (i != 0) begin
                check("t6_inv_msb", 32'(out_data[3]), 32'd1);
                check("t6_inv_restore", 32'(out_data >> out_shift), 32'(i));
            end
            $display("item t6_%0d: in=%b out_data=%b out_shift=%0d out_zero=%0d latency=%0d",
                     i, 4'(i), out_data, out_shift, out_zero, cyc);
            tick();
            check("t6_one_result", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/seq_normalizer.md
# seq_normalizer

Multi-cycle left normalizer that is the inverse companion of the team's barrel shifter. It takes a WIDTH-bit word and shifts it left one bit per cycle until the MSB is 1. It returns the normalized word and the shift amount that, applied as a logical right shift, restores the original value. It sits in front of shifter-based datapaths that need the leading-zero count, and uses valid/ready handshakes on both sides.

## Interface
- WIDTH, 4, data width; must be ≥ 2.
- SW, $clog2(WIDTH), width of the shift-amount output (derived; do not override).

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  WIDTH  word to normalize.
- out_valid  output  1  result is valid; high only in HOLD.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  normalized word.
- out_shift  output  SW  number of left shifts applied, 0..WIDTH-1.
- out_zero  output  1  input was all zeros.

## Operation
- The FSM has three states: IDLE, SHIFT and HOLD.
- Internal registers: work register (WIDTH bits), counter (SW bits), zero flag.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, the work register is loaded with in_data, the counter and zero flag are cleared, and the FSM goes to SHIFT.
- SHIFT (once per cycle):
  - If work==0: set zero flag, go to HOLD.
  - Else if work[WIDTH-1]==1: go to HOLD.
  - Else: work <= work<<1 with LSB filled by 0, counter <= counter+1, stay in SHIFT.
- HOLD:
  - out_valid=1; out_data, out_shift and out_zero are driven from the registers and held stable.
  - On out_valid && out_ready, go to IDLE. Register contents persist until the next load.
- Arithmetic:
  - The counter never exceeds WIDTH-1, because the loop terminates once the MSB reaches position WIDTH-1, so no overflow is possible.
  - Zero input gives out_data=0, out_shift=0, out_zero=1.
- Invariant for nonzero input: out_data[WIDTH-1]=1, out_zero=0, and (out_data >> out_shift) == in_data.
- No overlap: inputs presented outside IDLE are ignored, because in_ready=0 outside IDLE.
- Handshake rules:
  - in_valid may be held high indefinitely; a transfer happens on the first IDLE cycle.
  - The consumer may stall indefinitely in HOLD; out_* must not change while out_valid=1 && !out_ready.

## Timing
- Reset (rst_n=0, asynchronous, immediate):
  - FSM goes to IDLE; work, counter and zero flag go to 0.
  - Outputs: out_valid=0, out_data=0, out_shift=0, out_zero=0, in_ready=1.
- Reset mid-SHIFT or mid-HOLD aborts the operation with no output. The first rising edge after release samples in IDLE.
- Acceptance happens at edge E0. With k leading zeros (nonzero input), out_valid rises after edge E0+k+1. Zero input gives out_valid after E0+1.
- Result accepted at edge Ex: out_valid drops and in_ready rises after Ex. The next acceptance can occur at Ex+1.
- Minimum spacing between accepted inputs is k+3 cycles when out_ready is held high.
- in_ready, out_valid and out_* are decoded from registered state and registers only. There is no combinational path from inputs to outputs.

## Test plan
1. WIDTH=4, in_data=1010, out_ready=1:
   - out_valid goes high 1 cycle after acceptance.
   - Result: out_data=1010, out_shift=00, out_zero=0.
2. in_data=0001:
   - out_valid goes high 4 cycles after acceptance.
   - Result: out_data=1000, out_shift=11, out_zero=0.
3. in_data=0000:
   - out_valid goes high 1 cycle after acceptance.
   - Result: out_data=0000, out_shift=00, out_zero=1.
4. in_data=0110, out_ready held 0 for 5 cycles in HOLD, with in_valid=1 and in_data=1111 offered throughout:
   - Outputs hold out_data=1100, out_shift=01 stable.
   - in_ready stays 0 and 1111 is not captured until after out_ready=1.
   - 1111 is then captured: after out_ready=1, out_valid drops and in_ready rises; at the next edge in_valid=1 && in_ready=1 accepts 1111, giving out_data=1111, out_shift=00.
5. rst_n pulsed low during SHIFT of 0001:
   - out_valid=0 and in_ready=1 immediately.
   - After release, 1111 processes normally to out_data=1111, out_shift=00, with no residue from the aborted item.
6. All 16 inputs 0000..1111 back-to-back, out_ready=1, in_valid always 1:
   - Check the invariant and out_zero for every input.
   - Check latency of k+1 cycles.
   - Check exactly one result per accepted input, in order.
